dmem_bridge: RTL and testbench

- Sits directly downstream of the single-cycle datapath's ALUResult/WriteData outputs.
- Turns each load/store into one transaction on a valid/ready data bus, with byte-lane alignment and sign/zero extension.
- Returns ReadData to the result mux and holds the core with Stall until the access completes.
- Adds wait-state tolerance, a bus-error path and a timeout to an otherwise single-cycle core.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_bridge_lsu_align.sv | 73 +++++++
 rtl/dmem_bridge.sv | 172 +++++++++++++++++
 tb/tb_dmem_bridge.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory bridge: access size codes,
// FSM state encoding and the default REQ timeout.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/dmem_bridge_lsu_align.sv
// Byte-lane logic for the bridge: misalignment detect, store lane
// replication/strobes, and load extraction with sign/zero extension.
module lsu_align
  import dmem_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic        st_write,
  input  logic [31:0] st_wdata,
  output logic        misaligned,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Size code 11 has no legal access width, so it is reported as misaligned.
  always_comb begin
    misaligned = 1'b0;
    case (st_funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = st_off[0];
      2'b10:   misaligned = |st_off;
      default: misaligned = 1'b1;
    endcase
  end

  // Store data is replicated across lanes; strobes select the addressed bytes.
  always_comb begin
    wstrb = 4'b0000;
    wdata = st_wdata;
    if (st_write) begin
      case (st_funct3[1:0])
        2'b00: begin
          wstrb = 4'b0001 << st_off;
          wdata = {4{st_wdata[7:0]}};
        end
        2'b01: begin
          wstrb = 4'b0011 << st_off;
          wdata = {2{st_wdata[15:0]}};
        end
        2'b10: begin
          wstrb = 4'b1111;
          wdata = st_wdata;
        end
        default: begin
          wstrb = 4'b0000;
          wdata = st_wdata;
        end
      endcase
    end
  end

  // Pick the addressed byte/half from the returned word and extend it.
  always_comb begin
    ld_byte = ld_rdata[{ld_off, 3'b000} +: 8];
    ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_data = {24'h000000, ld_byte};
      F3_HU:   ld_data = {16'h0000, ld_half};
      F3_W:    ld_data = ld_rdata;
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// Load/store bridge between a single-cycle core and a valid/ready data bus.
// Holds the core with Stall while a transaction is outstanding.
//
//   state | meaning
//   IDLE  | no access in flight; a request here either launches or faults
//   REQ   | bus_valid asserted, payload held, waiting for bus_ready or timeout
//   DONE  | one-cycle completion; Fault pulses here, instruction retires
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic [2:0]    Funct3,
  input  logic [AW-1:0] ALUResult,
  input  logic [31:0]   WriteData,
  output logic [31:0]   ReadData,
  output logic          Stall,
  output logic          Fault,
  output logic          bus_valid,
  output logic          bus_write,
  output logic [AW-1:0] bus_addr,
  output logic [31:0]   bus_wdata,
  output logic [3:0]    bus_wstrb,
  input  logic          bus_ready,
  input  logic [31:0]   bus_rdata,
  input  logic          bus_err
);

  // REQ lasts at most TIMEOUT cycles; the counter starts at 0 in the first one.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          fault_q, fault_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          valid_q, valid_d;
  logic          write_q, write_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;

  logic          req;
  logic          al_mis;
  logic [3:0]    al_wstrb;
  logic [31:0]   al_wdata;
  logic [31:0]   al_ld;

  assign req = MemRead | MemWrite;

  lsu_align u_align (
    .st_funct3  (Funct3),
    .st_off     (ALUResult[1:0]),
    .st_write   (MemWrite),
    .st_wdata   (WriteData),
    .misaligned (al_mis),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .ld_funct3  (f3_q),
    .ld_off     (off_q),
    .ld_rdata   (bus_rdata),
    .ld_data    (al_ld)
  );

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = 1'b0;
    rdata_d = rdata_q;
    valid_d = valid_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    f3_d    = f3_q;
    off_d   = off_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (al_mis) begin
            state_d = DONE;
            fault_d = 1'b1;
            if (!MemWrite) rdata_d = 32'h0;
          end else begin
            state_d = REQ;
            valid_d = 1'b1;
            cnt_d   = 8'd0;
            write_d = MemWrite;
            addr_d  = {ALUResult[AW-1:2], 2'b00};
            wdata_d = al_wdata;
            wstrb_d = al_wstrb;
            f3_d    = Funct3;
            off_d   = ALUResult[1:0];
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_ready) begin
          state_d = DONE;
          valid_d = 1'b0;
          if (bus_err) begin
            fault_d = 1'b1;
            if (!write_q) rdata_d = 32'h0;
          end else if (!write_q) begin
            rdata_d = al_ld;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          valid_d = 1'b0;
          fault_d = 1'b1;
          if (!write_q) rdata_d = 32'h0;
        end
      end
      DONE: begin
        cnt_d   = 8'd0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      fault_q <= 1'b0;
      rdata_q <= 32'h0;
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'b0000;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  end

  assign Stall     = ((state_q == IDLE) & req) | (state_q == REQ);
  assign Fault     = fault_q;
  assign ReadData  = rdata_q;
  assign bus_valid = valid_q;
  assign bus_write = write_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_wstrb = wstrb_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed vector table, random
// accesses against a behavioural model, and reset/ignored-response sequences.
module tb_dmem_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData;
  logic [31:0] ReadData;
  logic        Stall, Fault;
  logic        bus_valid, bus_write;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready, bus_err;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rd;

  always #5 clk = ~clk;

  dmem_bridge #(.AW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
    .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .Fault(Fault),
    .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          waitc;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] exp_rd;
    logic        exp_fault;
    int          exp_stall;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input int waitc, input logic err, input logic [31:0] rdata,
                              input logic [31:0] exp_rd, input logic exp_fault,
                              input int exp_stall, input logic [3:0] exp_wstrb,
                              input logic [31:0] exp_wdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd;
    v.waitc = waitc; v.err = err; v.rdata = rdata;
    v.exp_rd = exp_rd; v.exp_fault = exp_fault; v.exp_stall = exp_stall;
    v.exp_wstrb = exp_wstrb; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  // Behavioural model: derive every expectation from the access rules.
  function automatic vec_t model(input vec_t v, input logic [31:0] prev_rd);
    vec_t e = v;
    int off = int'(v.addr % 4);
    int sz = int'(v.f3 % 4);
    int nb = 1 << sz;
    logic is_st = v.wr;
    logic mis = (sz == 1 && (off % 2) == 1) || (sz == 2 && off != 0) || (sz == 3);
    logic tout = (v.waitc + 1) > TO;
    logic [31:0] b = (v.rdata >> (8 * off)) & 32'hFF;
    logic [31:0] h = (v.rdata >> (16 * (off / 2))) & 32'hFFFF;
    logic [31:0] ext;
    case (v.f3)
      3'd0:    ext = (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      3'd1:    ext = (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      3'd4:    ext = b;
      3'd5:    ext = h;
      default: ext = v.rdata;
    endcase
    e.exp_wstrb = 4'b0000;
    e.exp_wdata = 32'h0;
    if (is_st && !mis)
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + nb) e.exp_wstrb[i] = 1'b1;
        e.exp_wdata[8*i +: 8] = v.wd[8*(i % nb) +: 8];
      end
    if (mis) begin
      e.exp_stall = 1;
      e.exp_fault = 1'b1;
      e.exp_rd = is_st ? prev_rd : 32'h0;
    end else if (tout) begin
      e.exp_stall = 1 + TO;
      e.exp_fault = 1'b1;
      e.exp_rd = is_st ? prev_rd : 32'h0;
    end else begin
      e.exp_stall = 1 + v.waitc + 1;
      e.exp_fault = v.err;
      e.exp_rd = is_st ? prev_rd : (v.err ? 32'h0 : ext);
    end
    return e;
  endfunction

  // Drive one access as the core and answer it as the slave.
  task automatic run_txn(input vec_t v);
    int stall_n = 0;
    int v_n = 0;
    bit done = 0;
    @(posedge clk); #1;
    MemRead = v.rd; MemWrite = v.wr; Funct3 = v.f3;
    ALUResult = v.addr; WriteData = v.wd;
    bus_ready = 1'b0; bus_err = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (Stall) begin
        stall_n++;
        chk("fault_during_stall", {31'b0, Fault}, 32'h0);
      end
      if (bus_valid) begin
        v_n++;
        chk("bus_addr", bus_addr, {v.addr[31:2], 2'b00});
        chk("bus_write", {31'b0, bus_write}, {31'b0, v.wr});
        chk("bus_wstrb", {28'b0, bus_wstrb}, {28'b0, v.exp_wstrb});
        if (v.wr) chk("bus_wdata", bus_wdata, v.exp_wdata);
        if (v_n == v.waitc + 1) begin
          bus_ready = 1'b1; bus_err = v.err; bus_rdata = v.rdata;
        end else begin
          bus_ready = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
        end
      end else begin
        bus_ready = 1'b0; bus_err = 1'b0;
      end
      if (!Stall) begin
        done = 1;
        chk("stall_cycles", stall_n, v.exp_stall);
        chk("valid_cycles", v_n, v.exp_stall - 1);
        chk("done_fault", {31'b0, Fault}, {31'b0, v.exp_fault});
        chk("done_rdata", ReadData, v.exp_rd);
        chk("done_valid", {31'b0, bus_valid}, 32'h0);
        MemRead = 1'b0; MemWrite = 1'b0;
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL txn_timeout actual=stuck required=done");
      MemRead = 1'b0; MemWrite = 1'b0;
      bus_ready = 1'b0; bus_err = 1'b0;
    end
    @(negedge clk);
    chk("fault_pulse_end", {31'b0, Fault}, 32'h0);
    chk("idle_stall", {31'b0, Stall}, 32'h0);
    model_rd = v.exp_rd;
  endtask

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b0;
    ALUResult = 32'h0; WriteData = 32'h0;
    bus_ready = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
    model_rd = 32'h0;

    //          rd wr f3      addr          wd            w  err rdata         exp_rd        flt stl wstrb    wdata
    vecs.push_back(mk(1, 0, 3'b010, 32'h100, 32'h0,        3, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 5, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 1, 3'b000, 32'h203, 32'h000000A5, 0, 0, 32'h0,        32'hDEADBEEF, 0, 2, 4'b1000, 32'hA5A5A5A5));
    vecs.push_back(mk(1, 0, 3'b000, 32'h102, 32'h0,        1, 0, 32'h1280FF00, 32'hFFFFFF80, 0, 3, 4'b0000, 32'h0));
    vecs.push_back(mk(1, 0, 3'b100, 32'h102, 32'h0,        0, 0, 32'h1280FF00, 32'h00000080, 0, 2, 4'b0000, 32'h0));
    vecs.push_back(mk(1, 0, 3'b101, 32'h106, 32'h0,        0, 0, 32'hBEEF1234, 32'h0000BEEF, 0, 2, 4'b0000, 32'h0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h101, 32'h0,        0, 0, 32'h0,        32'h0,        1, 1, 4'b0000, 32'h0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h102, 32'h0,        2, 0, 32'h80011234, 32'hFFFF8001, 0, 4, 4'b0000, 32'h0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h104, 32'h0,        0, 1, 32'h12345678, 32'h0,        1, 2, 4'b0000, 32'h0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h10C, 32'h0,        1, 0, 32'h0BADF00D, 32'h0BADF00D, 0, 3, 4'b0000, 32'h0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h108, 32'h0,       10, 0, 32'h0,        32'h0,        1, 5, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 0, 0, 32'h0,        32'h0,        0, 2, 4'b1100, 32'hABCDABCD));
    vecs.push_back(mk(1, 0, 3'b000, 32'h101, 32'h0,        0, 0, 32'h00007F00, 32'h0000007F, 0, 2, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 1, 3'b010, 32'h20C, 32'hCAFEF00D, 2, 0, 32'h0,        32'h0000007F, 0, 4, 4'b1111, 32'hCAFEF00D));
    vecs.push_back(mk(1, 1, 3'b010, 32'h300, 32'h11223344, 0, 0, 32'h0,        32'h0000007F, 0, 2, 4'b1111, 32'h11223344));
    vecs.push_back(mk(0, 1, 3'b010, 32'h302, 32'h55555555, 0, 0, 32'h0,        32'h0000007F, 1, 1, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 1, 3'b000, 32'h201, 32'h0000005A, 0, 1, 32'h0,        32'h0000007F, 1, 2, 4'b0010, 32'h5A5A5A5A));

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_readdata", ReadData, 32'h0);
    chk("rst_fault", {31'b0, Fault}, 32'h0);
    chk("rst_valid", {31'b0, bus_valid}, 32'h0);
    chk("rst_write", {31'b0, bus_write}, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_wstrb", {28'b0, bus_wstrb}, 32'h0);
    chk("rst_stall", {31'b0, Stall}, 32'h0);

    foreach (vecs[i]) run_txn(vecs[i]);

    // Random accesses checked against the model.
    for (int n = 0; n < 150; n++) begin
      vec_t v;
      logic [2:0] ld_codes[6];
      ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
      v.wr = ($urandom_range(0, 2) == 0);
      v.rd = v.wr ? ($urandom_range(0, 3) == 0) : 1'b1;
      v.f3 = v.wr ? 3'($urandom_range(0, 3)) : ld_codes[$urandom_range(0, 5)];
      v.addr = $urandom;
      v.wd = $urandom;
      v.waitc = $urandom_range(0, TO + 1);
      v.err = ($urandom_range(0, 5) == 0);
      v.rdata = $urandom;
      run_txn(model(v, model_rd));
    end

    // Responses while no request is outstanding must be ignored.
    @(negedge clk);
    bus_ready = 1'b1; bus_err = 1'b1; bus_rdata = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    chk("stray_fault", {31'b0, Fault}, 32'h0);
    chk("stray_rdata", ReadData, model_rd);
    chk("stray_valid", {31'b0, bus_valid}, 32'h0);
    bus_ready = 1'b0; bus_err = 1'b0;

    // Make ReadData nonzero, then reset during REQ.
    run_txn(mk(1, 0, 3'b010, 32'h400, 32'h0, 0, 0, 32'h600DCAFE, 32'h600DCAFE, 0, 2, 4'b0000, 32'h0));
    @(posedge clk); #1;
    MemWrite = 1'b1; MemRead = 1'b0; Funct3 = 3'b010; ALUResult = 32'h404; WriteData = 32'h77777777;
    @(negedge clk);
    chk("mid_idle_stall", {31'b0, Stall}, 32'h1);
    @(negedge clk);
    chk("mid_req_valid", {31'b0, bus_valid}, 32'h1);
    reset = 1'b1; MemWrite = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {31'b0, bus_valid}, 32'h0);
    chk("mid_rst_stall", {31'b0, Stall}, 32'h0);
    chk("mid_rst_rdata", ReadData, 32'h0);
    chk("mid_rst_fault", {31'b0, Fault}, 32'h0);
    chk("mid_rst_write", {31'b0, bus_write}, 32'h0);
    chk("mid_rst_addr", bus_addr, 32'h0);
    chk("mid_rst_wdata", bus_wdata, 32'h0);
    chk("mid_rst_wstrb", {28'b0, bus_wstrb}, 32'h0);
    reset = 1'b0;
    model_rd = 32'h0;
    run_txn(mk(1, 0, 3'b100, 32'h403, 32'h0, 1, 0, 32'hC3000000, 32'h000000C3, 0, 3, 4'b0000, 32'h0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
